// File: rtl/interrupt_controller_riscv_if.sv
// Core-side interrupt handshake between the controller and the RISC-V core.
// Signal names follow the controller's view (_i into it, _o out of it).
interface interrupt_controller_riscv_if;
  logic        int_o;
  logic [31:0] mcause_o;
  logic        int_rst_i;
  logic        stall_i;
  logic [31:0] mie_i;

  modport master (
    output int_o,
    output mcause_o,
    input  int_rst_i,
    input  stall_i,
    input  mie_i
  );

  modport slave (
    input  int_o,
    input  mcause_o,
    output int_rst_i,
    output stall_i,
    output mie_i
  );
endinterface

// File: rtl/interrupt_controller_riscv.sv
// Prioritising, non-nesting interrupt controller: sticky edge capture, mie masking,
// lowest-index-first delivery to the core, and a one-hot acknowledge on mret.
module interrupt_controller_riscv #(
  parameter int N_IRQ = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [N_IRQ-1:0]                    irq_req_i,
  output logic [N_IRQ-1:0]                    irq_ret_o,
  interrupt_controller_riscv_if.master        core_if
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_BUSY = 2'd2;

  logic [1:0]       state_q,   state_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] irq_prev_q;
  logic [3:0]       cur_id_q,  cur_id_d;
  logic             int_q,     int_d;
  logic [31:0]      mcause_q,  mcause_d;
  logic [N_IRQ-1:0] ret_q,     ret_d;

  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] cur_onehot;
  logic [N_IRQ-1:0] clr;
  logic [3:0]       win_id;
  logic             win_found;
  logic             unused_mie;

  assign unused_mie = ^core_if.mie_i;

  always_comb begin
    rise     = irq_req_i & ~irq_prev_q;
    eligible = pending_q & core_if.mie_i[16 +: N_IRQ];

    win_id    = '0;
    win_found = 1'b0;
    for (int unsigned k = 0; k < N_IRQ; k++) begin
      if (eligible[k] && !win_found) begin
        win_id    = 4'(k);
        win_found = 1'b1;
      end
    end

    cur_onehot = '0;
    for (int unsigned k = 0; k < N_IRQ; k++) begin
      cur_onehot[k] = (cur_id_q == 4'(k));
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    int_d    = int_q;
    mcause_d = mcause_q;
    ret_d    = '0;
    clr      = '0;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          cur_id_d = win_id;
          mcause_d = 32'h8000_0010 + {28'd0, win_id};
          int_d    = 1'b1;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (!core_if.stall_i) begin
          int_d   = 1'b0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (core_if.int_rst_i) begin
          clr     = cur_onehot;
          ret_d   = cur_onehot;
          state_d = S_IDLE;
        end
      end
      default: begin
        int_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Set after clear: a fresh edge coinciding with mret is not lost.
    pending_d = (pending_q & ~clr) | rise;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      pending_q  <= '0;
      irq_prev_q <= '0;
      cur_id_q   <= '0;
      int_q      <= 1'b0;
      mcause_q   <= '0;
      ret_q      <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      irq_prev_q <= irq_req_i;
      cur_id_q   <= cur_id_d;
      int_q      <= int_d;
      mcause_q   <= mcause_d;
      ret_q      <= ret_d;
    end
  end

  assign core_if.int_o    = int_q;
  assign core_if.mcause_o = mcause_q;
  assign irq_ret_o        = ret_q;

endmodule

// File: tb/tb_interrupt_controller_riscv.sv
// Directed bench for interrupt_controller_riscv with hand-computed expectations.
module tb_interrupt_controller_riscv;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] irq_req_i;
  logic [15:0] irq_ret_o;
  int          n_checks = 0;
  int          n_errors = 0;
  logic        seen_int;

  interrupt_controller_riscv_if core_if();

  interrupt_controller_riscv #(.N_IRQ(16)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .irq_req_i (irq_req_i),
    .irq_ret_o (irq_ret_o),
    .core_if   (core_if)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Acknowledge and request must never overlap.
  always @(negedge clk_i) begin
    if (rst_i === 1'b0)
      check_eq("ret_int_exclusive", {31'd0, core_if.int_o & (|irq_ret_o)}, 32'd0);
  end

  initial begin
    rst_i             = 1'b1;
    irq_req_i         = '0;
    core_if.int_rst_i = 1'b0;
    core_if.stall_i   = 1'b0;
    core_if.mie_i     = 32'h0001_0000;
    tick();
    tick();
    check_eq("rst_int", {31'd0, core_if.int_o}, 32'd0);
    check_eq("rst_mcause", core_if.mcause_o, 32'd0);
    check_eq("rst_ret", {16'd0, irq_ret_o}, 32'd0);
    rst_i = 1'b0;
    tick();

    // Basic delivery of source 0
    irq_req_i[0] = 1'b1;
    tick();
    irq_req_i[0] = 1'b0;
    check_eq("basic_int_e0", {31'd0, core_if.int_o}, 32'd0);
    tick();
    check_eq("basic_int_e1", {31'd0, core_if.int_o}, 32'd1);
    check_eq("basic_mcause", core_if.mcause_o, 32'h8000_0010);
    tick();
    check_eq("basic_int_len", {31'd0, core_if.int_o}, 32'd0);
    check_eq("basic_mcause_hold", core_if.mcause_o, 32'h8000_0010);
    core_if.int_rst_i = 1'b1;
    tick();
    core_if.int_rst_i = 1'b0;
    check_eq("basic_ret", {16'd0, irq_ret_o}, 32'h0000_0001);
    tick();
    check_eq("basic_ret_len", {16'd0, irq_ret_o}, 32'd0);
    tick();
    tick();
    check_eq("basic_cleared", {31'd0, core_if.int_o}, 32'd0);

    // Priority: 2 before 5
    core_if.mie_i = 32'hFFFF_0000;
    irq_req_i[5]  = 1'b1;
    irq_req_i[2]  = 1'b1;
    tick();
    irq_req_i = '0;
    tick();
    check_eq("prio_int1", {31'd0, core_if.int_o}, 32'd1);
    check_eq("prio_mcause1", core_if.mcause_o, 32'h8000_0012);
    tick();
    core_if.int_rst_i = 1'b1;
    tick();
    core_if.int_rst_i = 1'b0;
    check_eq("prio_ret1", {16'd0, irq_ret_o}, 32'h0000_0004);
    check_eq("prio_gap", {31'd0, core_if.int_o}, 32'd0);
    tick();
    check_eq("prio_int2", {31'd0, core_if.int_o}, 32'd1);
    check_eq("prio_mcause2", core_if.mcause_o, 32'h8000_0015);
    tick();
    core_if.int_rst_i = 1'b1;
    tick();
    core_if.int_rst_i = 1'b0;
    check_eq("prio_ret2", {16'd0, irq_ret_o}, 32'h0000_0020);
    tick();

    // Masking, then stall handshake on the unmasked source
    core_if.mie_i = 32'h0;
    irq_req_i[3]  = 1'b1;
    seen_int      = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen_int = seen_int | core_if.int_o;
    end
    irq_req_i[3] = 1'b0;
    check_eq("mask_no_int", {31'd0, seen_int}, 32'd0);
    core_if.mie_i = 32'h0008_0000;
    tick();
    check_eq("mask_int", {31'd0, core_if.int_o}, 32'd1);
    check_eq("mask_mcause", core_if.mcause_o, 32'h8000_0013);
    core_if.stall_i   = 1'b1;
    core_if.int_rst_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      core_if.int_rst_i = 1'b0;
      check_eq("stall_int", {31'd0, core_if.int_o}, 32'd1);
      check_eq("stall_mcause", core_if.mcause_o, 32'h8000_0013);
      check_eq("stall_no_ret", {16'd0, irq_ret_o}, 32'd0);
    end
    core_if.stall_i = 1'b0;
    tick();
    check_eq("stall_accept", {31'd0, core_if.int_o}, 32'd0);
    check_eq("stall_no_ret2", {16'd0, irq_ret_o}, 32'd0);
    core_if.int_rst_i = 1'b1;
    tick();
    core_if.int_rst_i = 1'b0;
    check_eq("stall_ret", {16'd0, irq_ret_o}, 32'h0000_0008);
    tick();

    // Reset mid-BUSY with source 1 held high
    core_if.mie_i = 32'hFFFF_0000;
    irq_req_i[1]  = 1'b1;
    tick();
    tick();
    check_eq("rstb_int", {31'd0, core_if.int_o}, 32'd1);
    check_eq("rstb_mcause", core_if.mcause_o, 32'h8000_0011);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_eq("rstb_out_int", {31'd0, core_if.int_o}, 32'd0);
    check_eq("rstb_out_mcause", core_if.mcause_o, 32'd0);
    check_eq("rstb_out_ret", {16'd0, irq_ret_o}, 32'd0);
    tick();
    check_eq("rstb_e0_int", {31'd0, core_if.int_o}, 32'd0);
    check_eq("rstb_e0_ret", {16'd0, irq_ret_o}, 32'd0);
    tick();
    check_eq("rstb_reint", {31'd0, core_if.int_o}, 32'd1);
    check_eq("rstb_remcause", core_if.mcause_o, 32'h8000_0011);
    tick();
    irq_req_i[1]      = 1'b0;
    core_if.int_rst_i = 1'b1;
    tick();
    core_if.int_rst_i = 1'b0;
    check_eq("rstb_ret", {16'd0, irq_ret_o}, 32'h0000_0002);
    tick();

    // Set/clear collision on source 4
    irq_req_i[4] = 1'b1;
    tick();
    irq_req_i[4] = 1'b0;
    tick();
    check_eq("coll_int", {31'd0, core_if.int_o}, 32'd1);
    check_eq("coll_mcause", core_if.mcause_o, 32'h8000_0014);
    tick();
    irq_req_i[4]      = 1'b1;
    core_if.int_rst_i = 1'b1;
    tick();
    core_if.int_rst_i = 1'b0;
    check_eq("coll_ret", {16'd0, irq_ret_o}, 32'h0000_0010);
    tick();
    check_eq("coll_redeliver", {31'd0, core_if.int_o}, 32'd1);
    check_eq("coll_remcause", core_if.mcause_o, 32'h8000_0014);
    tick();
    core_if.int_rst_i = 1'b1;
    tick();
    core_if.int_rst_i = 1'b0;
    check_eq("coll_ret2", {16'd0, irq_ret_o}, 32'h0000_0010);
    seen_int = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen_int = seen_int | core_if.int_o;
    end
    check_eq("coll_no_third", {31'd0, seen_int}, 32'd0);
    irq_req_i = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/interrupt_controller_riscv.md
# interrupt_controller_riscv

Prioritising interrupt controller between up to 16 peripheral interrupt lines and the core's interrupt interface (`int_i`, `mcause_i`, `int_rst_o`, `mie_o`). It does four things:
- Captures rising edges on the request lines as sticky pending bits.
- Masks pending bits with the core's `mie` CSR.
- Selects the highest-priority enabled source and hands it to the core with a stall-aware handshake.
- Holds the source in service until the core executes `mret`, then acknowledges the peripheral.

Only one interrupt is in service at any time; there is no nesting.

## Interface
Parameters:
- `N_IRQ`, default 16: number of request lines. Legal range is 1..16.

Ports:
- `clk_i`, input, 1: clock. All state changes on the rising edge.
- `rst_i`, input, 1: reset, synchronous, active-high.
- `irq_req_i`, input, N_IRQ: peripheral request lines. Level input; a rising edge is an event.
- `mie_i`, input, 32: mask from the core's `mie_o`. Bit 16+k enables source k.
- `stall_i`, input, 1: core LSU stall. Delivery is not accepted while high.
- `int_rst_i`, input, 1: one-cycle pulse from the core when `mret` retires.
- `int_o`, output, 1: interrupt request to the core's `int_i`.
- `mcause_o`, output, 32: cause to the core's `mcause_i`.
- `irq_ret_o`, output, N_IRQ: one-hot, one-cycle acknowledge to the serviced peripheral.

## Operation
**Edge capture**
- `irq_prev` register holds the previous sample of `irq_req_i`.
- `pending[k]` is set when `irq_req_i[k] & ~irq_prev[k]`.
- A set and a clear of the same bit in the same cycle: set wins, so the new event is kept.

**Selection**
- Eligible bits are `pending[k] & mie_i[16+k]`.
- Lowest index has highest priority.
- Selection is evaluated only in IDLE. The winner is latched into `cur_id`, 4 bits.

**FSM states**
- IDLE:
  - If any bit is eligible, latch `cur_id`, load `mcause_o = 32'h8000_0010 + cur_id`, and go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - `int_o = 1`.
  - On an edge with `stall_i == 0` (accepted), go to BUSY.
  - While `stall_i == 1`, hold REQ with `int_o` and `mcause_o` stable.
- BUSY:
  - `int_o = 0`.
  - On `int_rst_i == 1`: clear `pending[cur_id]`, drive `irq_ret_o = 1 << cur_id` for the next cycle, and go to IDLE.

**Rules in every state**
- `int_rst_i` outside BUSY is ignored.
- `mcause_o` holds its last value until the next IDLE→REQ load.
- Changes to `mie_i` while in REQ or BUSY do not withdraw or alter the request in flight.
- A masked pending bit stays pending indefinitely. It is delivered once it is unmasked.
- New edges on any line, including `cur_id`'s own, are captured at all times.

**Reset**
- Reset values: state = IDLE, `pending` = 0, `irq_prev` = 0, `cur_id` = 0, `int_o` = 0, `mcause_o` = 0, `irq_ret_o` = 0.
- Reset overrides everything in the same cycle, including mid-REQ and mid-BUSY. No acknowledge is issued for an aborted service.
- Because `irq_prev` resets to 0, a line held high through reset is captured as an event on the first edge after reset.

## Timing
- All outputs are registered.
- Latency from request to `int_o`:
  - Edge E0 samples `irq_req_i[k]` rising, and `pending[k]` is set after E0.
  - At E1, IDLE moves to REQ if the source is enabled.
  - `int_o` is high in the cycle after E1, which is 2 cycles after the sampling edge.
- `int_o` is high for exactly (stall cycles + 1) cycles.
- Acknowledge timing:
  - If `int_rst_i` is sampled high at edge Er, `irq_ret_o` is high for the single cycle after Er.
  - The state is IDLE after Er.
- Back-to-back delivery: the next source's `int_o` rises 2 cycles after Er, because IDLE is visited for at least one cycle.
- `irq_ret_o` is never asserted in the same cycle as `int_o`.

## Test plan
- **Basic delivery.** N_IRQ=16, `mie_i=32'h0001_0000`, pulse `irq_req_i[0]`.
  - `int_o` rises 2 cycles after the sampling edge, lasts 1 cycle, with `mcause_o=32'h8000_0010`.
  - Pulse `int_rst_i`: `irq_ret_o=16'h0001` for 1 cycle, and `pending[0]` is cleared.
- **Priority.** Raise `irq_req_i[5]` and `irq_req_i[2]` on the same edge, `mie_i=32'hFFFF_0000`.
  - First service has `mcause_o=32'h8000_0012`.
  - After `int_rst_i`, second service has `mcause_o=32'h8000_0015` with `int_o` 2 cycles after the ack edge.
- **Masking.** `irq_req_i[3]` rises with `mie_i=0`.
  - No `int_o` for 20 cycles.
  - Set `mie_i[19]=1`: `int_o` is asserted 1 cycle later with `mcause_o=32'h8000_0013`.
- **Stall handshake.** Hold `stall_i=1` for 4 cycles during REQ.
  - `int_o` and `mcause_o` are held stable for 5 cycles, then the FSM is in BUSY.
  - An `int_rst_i` pulse before acceptance produces no `irq_ret_o`.
- **Reset mid-BUSY with a re-edge.** In BUSY on source 1, assert `rst_i` for 1 cycle while `irq_req_i[1]` is held high.
  - Outputs are 0 and no `irq_ret_o` appears.
  - Source 1 is re-captured and `int_o` is reasserted 2 cycles after reset deasserts.
- **Set/clear collision.** While source 4 is in BUSY, toggle `irq_req_i[4]` so that its rising edge coincides with the `int_rst_i` edge.
  - `irq_ret_o=16'h0010` is issued.
  - `pending[4]` remains 1, and source 4 is delivered again.
